// File: rtl/mul_div_unit_pkg.sv
// Shared CPU definitions: datapath width and the mul/div opcode encoding.
// Imported by mul_div_unit, md_div_step and the hazard unit.
package CPU_def;

  localparam int PC_BITS = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  function automatic logic is_mul_div(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_md_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Shifts the next dividend bit into the remainder and subtracts when it fits.
module md_div_step
  import CPU_def::*;
#(
  parameter int DATA_W = PC_BITS
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    // The difference always fits DATA_W bits when the subtract is taken.
    diff    = shifted[DATA_W-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_out = diff;
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. Latency: ITERS+1 busy cycles per
// mul/div (1 for MULT/MULTU when MD_FAST_MUL_EN is defined); MTHI/MTLO write at accept.
// Backpressure: md_busy_e stalls the pipeline; ops are only accepted while idle.
module mul_div_unit
  import CPU_def::*;
#(
  parameter int DATA_W = PC_BITS,
  parameter int ITERS  = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] src_a_e,
  input  logic [DATA_W-1:0] src_b_e,
  input  md_op_t            md_op_e,
  input  logic              flush_e,
  output logic              md_busy_e,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] a_abs_q, b_abs_q, a_raw_q;
  logic [DATA_W-1:0] acc_hi, acc_lo;  // mul: partial product / multiplier; div: remainder / quotient
  logic              is_div_q, neg_res_q, neg_rem_q, dz_q;

  logic              accept, op_signed, op_div, a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;

  always_comb begin
    accept    = (state == S_IDLE) && !flush_e && (md_op_e != MD_NONE);
    op_signed = (md_op_e == MD_MULT) || (md_op_e == MD_DIV);
    op_div    = (md_op_e == MD_DIV) || (md_op_e == MD_DIVU);
    a_neg     = op_signed && src_a_e[DATA_W-1];
    b_neg     = op_signed && src_b_e[DATA_W-1];
    a_abs     = a_neg ? -src_a_e : src_a_e;
    b_abs     = b_neg ? -src_b_e : src_b_e;
  end

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_nxt, mul_lo_nxt, div_rem_nxt, div_quo_nxt;

  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_abs_q} : '0);
    mul_hi_nxt = mul_sum[DATA_W:1];
    mul_lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};
  end

  md_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_in  (acc_hi),
    .quo_in  (acc_lo),
    .divisor (b_abs_q),
    .rem_out (div_rem_nxt),
    .quo_out (div_quo_nxt)
  );

  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  always_comb begin
`ifdef MD_FAST_MUL_EN
    prod = {{DATA_W{1'b0}}, a_abs_q} * {{DATA_W{1'b0}}, b_abs_q};
`else
    prod = {acc_hi, acc_lo};
`endif
    prod_s = neg_res_q ? -prod : prod;
    if (is_div_q) begin
      if (dz_q) begin
        fix_lo = '1;
        fix_hi = a_raw_q;
      end else begin
        fix_lo = neg_res_q ? -acc_lo : acc_lo;
        fix_hi = neg_rem_q ? -acc_hi : acc_hi;
      end
    end else begin
      {fix_hi, fix_lo} = prod_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
      a_abs_q   <= '0;
      b_abs_q   <= '0;
      a_raw_q   <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && md_op_e == MD_MTHI) hi_out <= src_a_e;
          if (accept && md_op_e == MD_MTLO) lo_out <= src_a_e;
          if (accept && is_mul_div(md_op_e)) begin
            a_abs_q   <= a_abs;
            b_abs_q   <= b_abs;
            a_raw_q   <= src_a_e;
            is_div_q  <= op_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= (src_b_e == '0);
            acc_hi    <= '0;
            acc_lo    <= op_div ? a_abs : b_abs;
            cnt       <= '0;
`ifdef MD_FAST_MUL_EN
            state     <= op_div ? S_RUN : S_FIX;
`else
            state     <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc_hi <= is_div_q ? div_rem_nxt : mul_hi_nxt;
          acc_lo <= is_div_q ? div_quo_nxt : mul_lo_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi_out <= fix_hi;
          lo_out <= fix_lo;
          cnt    <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md_busy_e = (state != S_IDLE);

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage. Consumes the forwarded operands src_a_e/src_b_e from the operand-forwarding muxes.
- Owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives md_busy_e to the hazard unit, which stalls any HI/LO consumer or new mul/div op until the unit is idle.

Parameters:
- DATA_W, default PC_BITS (32): operand and HI/LO width.
- ITERS, default DATA_W: iteration cycles per mul/div.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- src_a_e  in  DATA_W  forwarded operand A (rs)
- src_b_e  in  DATA_W  forwarded operand B (rt)
- md_op_e  in  3  md_op_t: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- flush_e  in  1  execute-stage flush; suppresses accept this cycle
- md_busy_e  out  1  high while an operation is in flight
- hi_out  out  DATA_W  HI register
- lo_out  out  DATA_W  LO register

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset: state=IDLE, md_busy_e=0, hi_out=0, lo_out=0, counter=0. Reset mid-operation aborts it; HI/LO go to 0.
- Accept: only in IDLE, with flush_e=0 and md_op_e != MD_NONE. While busy, md_op_e is ignored; the hazard unit guarantees it is held.
- MTHI/MTLO: hi_out or lo_out ← src_a_e at the accept edge. No busy.
- MULT/MULTU/DIV/DIVU: the accept edge latches |A|, |B| (raw values for unsigned ops), result sign, remainder sign (= sign of A), and div-by-zero flag (B==0). State → RUN, counter=0.
- FSM:
  - IDLE → RUN on mul/div accept.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle. Counter increments; at counter==ITERS-1 → FIX.
  - FIX: applies two's-complement negation where the sign flags require it, writes HI/LO, → IDLE.
- md_busy_e = (state != IDLE), registered. High for exactly ITERS+1 cycles starting the cycle after accept. HI/LO are new in the first cycle md_busy_e is low again.
- Mul result: 2·DATA_W-bit product. HI = upper half, LO = lower half. Signed product negated when operand signs differ.
- Div result:
  - LO = quotient, HI = remainder.
  - Quotient negated when operand signs differ; remainder takes the sign of the dividend.
- Div by zero: constant latency. LO = all ones, HI = src_a_e as latched, regardless of signedness.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- flush_e in a non-accept cycle has no effect. An in-flight op always completes.
- hi_out/lo_out hold stable at all times except the writing edge.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the product combinationally from the latched operands.
  - RUN is skipped (IDLE → FIX), so md_busy_e is high for exactly 1 cycle.
  - DIV/DIVU are unchanged.
- Undefined: all mul/div ops use the iterative path with ITERS+1 busy cycles.

Decomposition:
- The md_op_t enum (3-bit) and the MD_* encodings go in the shared CPU_def package next to PC_BITS.
- The hazard unit imports md_op_t.
- One natural sub-module: md_div_step. Combinational single restoring-division step: remainder/quotient in, remainder/quotient out. Instantiated once inside the RUN datapath.
- Sign handling and the multiplier step stay in mul_div_unit.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=7 → md_busy_e high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 33 busy cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU A=100, B=0 → LO=0xFFFFFFFF, HI=100, busy 33 cycles.
- MTHI A=0x1234 → hi_out=0x1234 next cycle, md_busy_e stays 0. Same with flush_e=1 → hi_out unchanged.
- Reset asserted on cycle 10 of a DIV → next cycle md_busy_e=0, HI=LO=0. A MULTU 3×5 issued while busy with another op is ignored. With MD_FAST_MUL_EN, MULT 6×7 → busy 1 cycle, LO=42, HI=0.
